// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate generator:
// format encoding, base opcodes and the output-width legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_B   = 3'b001,
    FMT_S   = 3'b010,
    FMT_U   = 3'b011,
    FMT_J   = 3'b100,
    FMT_Z   = 3'b101,
    FMT_SH  = 3'b110,
    FMT_ILL = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: slices the instruction word according
// to the selected format and extends it to XLEN bits.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     Instr_i,
  input  imm_fmt_e        Format_i,
  output logic [XLEN-1:0] ImmExt_o
);

  // The opcode field never contributes to an immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^Instr_i[6:0];

  // Signed size casts sign-extend from Instr_i[31] to the full width.
  always_comb begin
    ImmExt_o = '0;
    case (Format_i)
      FMT_I:   ImmExt_o = XLEN'($signed(Instr_i[31:20]));
      FMT_B:   ImmExt_o = XLEN'($signed({Instr_i[31], Instr_i[7], Instr_i[30:25],
                                         Instr_i[11:8], 1'b0}));
      FMT_S:   ImmExt_o = XLEN'($signed({Instr_i[31:25], Instr_i[11:7]}));
      FMT_U:   ImmExt_o = XLEN'($signed({Instr_i[31:12], 12'b0}));
      FMT_J:   ImmExt_o = XLEN'($signed({Instr_i[31], Instr_i[19:12], Instr_i[20],
                                         Instr_i[30:21], 1'b0}));
      FMT_Z:   ImmExt_o = XLEN'(Instr_i[19:15]);
      FMT_SH: begin
        if (XLEN == 64) ImmExt_o = XLEN'(Instr_i[25:20]);
        else            ImmExt_o = XLEN'(Instr_i[24:20]);
      end
      default: ImmExt_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: explicit or opcode-derived format, one-cycle
// latency, and a 2-entry skid buffer between decode and execute.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic [31:0]          Instr_i,
  input  logic [2:0]           ImmSrc_i,
  input  logic                 UseAuto_i,
  input  logic [TAG_WIDTH-1:0] Tag_i,
  output logic                 Valid_o,
  input  logic                 Ready_i,
  output logic [XLEN-1:0]      ImmExt_o,
  output logic [2:0]           Format_o,
  output logic                 Illegal_o,
  output logic [TAG_WIDTH-1:0] Tag_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned BW = XLEN + 3 + 1 + TAG_WIDTH;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  imm_fmt_e        w_auto_fmt;
  logic            w_auto_narrow;
  imm_fmt_e        w_fmt;
  logic [31:0]     w_instr_x;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic [BW-1:0]   w_beat;
  logic            w_in;
  logic            w_out;

  logic [1:0]      r_state;
  logic            r_valid;
  logic            r_ready;
  logic [BW-1:0]   r_out;
  logic [BW-1:0]   r_skid;

  assign w_opcode   = Instr_i[6:0];
  assign w_funct3   = Instr_i[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    w_auto_fmt    = FMT_ILL;
    w_auto_narrow = 1'b0;
    case (w_opcode)
      OP_IMM:       w_auto_fmt = w_is_shift ? FMT_SH : FMT_I;
      LOAD, JALR:   w_auto_fmt = FMT_I;
      STORE:        w_auto_fmt = FMT_S;
      BRANCH:       w_auto_fmt = FMT_B;
      LUI, AUIPC:   w_auto_fmt = FMT_U;
      JAL:          w_auto_fmt = FMT_J;
      SYSTEM:       w_auto_fmt = w_funct3[2] ? FMT_Z : FMT_I;
      OP_IMM_32: begin
        if (XLEN == 64) begin
          w_auto_fmt    = w_is_shift ? FMT_SH : FMT_I;
          w_auto_narrow = w_is_shift;
        end
      end
      default:      w_auto_fmt = FMT_ILL;
    endcase
  end

  assign w_fmt = UseAuto_i ? w_auto_fmt : imm_fmt_e'(ImmSrc_i);

  // Word shifts take a 5-bit shamt even on RV64: clearing bit 25 before the
  // shared extractor narrows the SH field without a second format code.
  always_comb begin
    w_instr_x = Instr_i;
    if (UseAuto_i && w_auto_narrow) w_instr_x[25] = 1'b0;
  end

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .Instr_i  (w_instr_x),
    .Format_i (w_fmt),
    .ImmExt_o (w_imm)
  );

  assign w_ill  = (w_fmt == FMT_ILL);
  assign w_beat = {(w_ill ? '0 : w_imm), 3'(w_fmt), w_ill, Tag_i};

  assign w_in  = Valid_i && r_ready;
  assign w_out = r_valid && Ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            r_out   <= w_beat;
            r_valid <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_in, w_out})
            2'b11: r_out <= w_beat;
            2'b10: begin
              r_skid  <= w_beat;
              r_ready <= 1'b0;
              r_state <= ST_FULL;
            end
            2'b01: begin
              r_valid <= 1'b0;
              r_state <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (w_out) begin
            r_out   <= r_skid;
            r_ready <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign Valid_o   = r_valid;
  assign Ready_o   = r_ready;
  assign ImmExt_o  = r_out[BW-1 -: XLEN];
  assign Format_o  = r_out[TAG_WIDTH+3 -: 3];
  assign Illegal_o = r_out[TAG_WIDTH];
  assign Tag_o     = r_out[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance share the
// same input stream and are checked against hand-computed immediates.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic        useauto;
  logic [7:0]  tag_i;
  logic        ready_i;

  logic        v32, r32, ill32, v64, r64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  tag32, tag64;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_WIDTH(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .Valid_i(valid_i), .Ready_o(r32),
    .Instr_i(instr), .ImmSrc_i(immsrc), .UseAuto_i(useauto), .Tag_i(tag_i),
    .Valid_o(v32), .Ready_i(ready_i), .ImmExt_o(imm32), .Format_o(fmt32),
    .Illegal_o(ill32), .Tag_o(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_WIDTH(8)) dut64 (
    .clk_i(clk), .rst_i(rst), .Valid_i(valid_i), .Ready_o(r64),
    .Instr_i(instr), .ImmSrc_i(immsrc), .UseAuto_i(useauto), .Tag_i(tag_i),
    .Valid_o(v64), .Ready_i(ready_i), .ImmExt_o(imm64), .Format_o(fmt64),
    .Illegal_o(ill64), .Tag_o(tag64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] ins, input logic [7:0] t);
    valid_i = 1'b1;
    useauto = 1'b1;
    instr   = ins;
    tag_i   = t;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; instr = '0; immsrc = '0;
    useauto = 1'b0; tag_i = '0; ready_i = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid32", 64'(v32), 64'd0);
    chk("rst_ready32", 64'(r32), 64'd1);
    chk("rst_imm32",   64'(imm32), 64'd0);
    chk("rst_fmt32",   64'(fmt32), 64'd0);
    chk("rst_ill32",   64'(ill32), 64'd0);
    chk("rst_tag32",   64'(tag32), 64'd0);
    chk("rst_valid64", 64'(v64), 64'd0);
    chk("rst_ready64", 64'(r64), 64'd1);

    // addi x1,x0,-1
    beat(32'hFFF00093, 8'h01);
    tick();
    chk("addi_valid", 64'(v32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_fmt",   64'(fmt32), 64'd0);
    chk("addi_tag",   64'(tag32), 64'h01);
    chk("addi_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);

    // beq -4
    beat(32'hFE000EE3, 8'h02);
    tick();
    chk("beq_imm32", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_fmt",   64'(fmt32), 64'd1);
    chk("beq_tag",   64'(tag32), 64'h02);

    // srai 5: funct7 bit 30 must not leak into the shamt
    beat(32'h4050D093, 8'h03);
    tick();
    chk("srai_imm32", 64'(imm32), 64'd5);
    chk("srai_fmt",   64'(fmt32), 64'd6);
    chk("srai_imm64", imm64, 64'd5);

    // lui 0x80000
    beat(32'h80000537, 8'h04);
    tick();
    chk("lui_imm32", 64'(imm32), 64'h80000000);
    chk("lui_imm64", imm64, 64'hFFFFFFFF_80000000);
    chk("lui_fmt",   64'(fmt64), 64'd3);

    // csrrwi uimm 31
    beat(32'h300FD073, 8'h05);
    tick();
    chk("csri_imm64", imm64, 64'h1F);
    chk("csri_fmt",   64'(fmt64), 64'd5);

    // jal with only the sign bit set
    beat(32'h8000006F, 8'h06);
    tick();
    chk("jal_imm32", 64'(imm32), 64'hFFF00000);
    chk("jal_fmt",   64'(fmt32), 64'd4);

    // slliw with bit 25 set: RV64 keeps 5 bits, RV32 has no such opcode
    beat(32'h0220909B, 8'h07);
    tick();
    chk("slliw_imm64", imm64, 64'd2);
    chk("slliw_fmt64", 64'(fmt64), 64'd6);
    chk("slliw_ill32", 64'(ill32), 64'd1);
    chk("slliw_imm32", 64'(imm32), 64'd0);

    // explicit S format
    beat(32'hFE112E23, 8'h08);
    useauto = 1'b0; immsrc = 3'b010;
    tick();
    chk("sfmt_imm32", 64'(imm32), 64'hFFFFFFFC);
    chk("sfmt_fmt",   64'(fmt32), 64'd2);

    // explicit illegal code on an all-ones word
    beat(32'hFFFFFFFF, 8'h09);
    useauto = 1'b0; immsrc = 3'b111;
    tick();
    chk("ill_src_valid", 64'(v32), 64'd1);
    chk("ill_src_flag",  64'(ill32), 64'd1);
    chk("ill_src_imm64", imm64, 64'd0);
    chk("ill_src_fmt",   64'(fmt32), 64'd7);

    // unknown opcode under auto-decode
    beat(32'hFFFFFFFF, 8'h0A);
    tick();
    chk("ill_op_flag", 64'(ill64), 64'd1);
    chk("ill_op_imm",  imm64, 64'd0);
    chk("ill_op_tag",  64'(tag64), 64'h0A);

    valid_i = 1'b0;
    tick();
    chk("drain_valid", 64'(v32), 64'd0);

    // backpressure: three beats against a stalled consumer
    ready_i = 1'b0;
    beat(32'h00100093, 8'hA0);
    tick();
    chk("bp_a_imm",   64'(imm32), 64'd1);
    chk("bp_a_ready", 64'(r32), 64'd1);
    beat(32'h00200093, 8'hB0);
    tick();
    chk("bp_full_ready", 64'(r32), 64'd0);
    chk("bp_hold_imm",   64'(imm32), 64'd1);
    beat(32'h00300093, 8'hC0);
    tick();
    chk("bp_stall_ready", 64'(r32), 64'd0);
    chk("bp_stall_tag",   64'(tag32), 64'hA0);
    ready_i = 1'b1;
    tick();
    chk("bp_b_imm",   64'(imm32), 64'd2);
    chk("bp_b_tag",   64'(tag32), 64'hB0);
    chk("bp_b_ready", 64'(r32), 64'd1);
    tick();
    chk("bp_c_imm",   64'(imm32), 64'd3);
    chk("bp_c_tag",   64'(tag64), 64'hC0);
    chk("bp_c_valid", 64'(v64), 64'd1);
    valid_i = 1'b0;
    tick();
    chk("bp_empty", 64'(v32), 64'd0);

    // reset while FULL discards both buffered beats
    ready_i = 1'b0;
    beat(32'h00700093, 8'hD0);
    tick();
    beat(32'h00800093, 8'hE0);
    tick();
    chk("rf_full_ready", 64'(r64), 64'd0);
    rst = 1'b1;
    beat(32'h00900093, 8'hF0);
    ready_i = 1'b1;
    tick();
    rst = 1'b0; valid_i = 1'b0;
    chk("rf_valid", 64'(v32), 64'd0);
    chk("rf_ready", 64'(r32), 64'd1);
    chk("rf_imm",   64'(imm32), 64'd0);
    beat(32'h00500093, 8'h55);
    tick();
    chk("rf_one_valid", 64'(v32), 64'd1);
    chk("rf_one_imm",   64'(imm32), 64'd5);
    chk("rf_one_tag",   64'(tag32), 64'h55);
    valid_i = 1'b0;
    tick();
    chk("rf_alone", 64'(v32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
